// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers.
// Used by both the read-side and write-side pointer blocks.
package fifo_pkg;

    localparam int MAX_W = 32;

    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    // Zero-extended inputs give zero-extended results, so callers may truncate.
    function automatic logic [MAX_W-1:0] bin2gray(
        input logic [MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(
        input logic [MAX_W-1:0] g
    );
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side pointer/flag bundle between consumer, synchronizer and rptr_empty.
interface rptr_empty_if #(
    parameter int PTR_WIDTH = 5
);
    logic                 rd_en_i;
    logic [PTR_WIDTH:0]   wp2rp_gray_i;
    logic [PTR_WIDTH:0]   rptr_gray_o;
    logic [PTR_WIDTH-1:0] raddr_o;
    logic                 empty_o;
    logic                 almost_empty_o;
    logic [PTR_WIDTH:0]   rd_count_o;
    logic                 underflow_o;

    modport master (
        output rd_en_i,
        output wp2rp_gray_i,
        input  rptr_gray_o,
        input  raddr_o,
        input  empty_o,
        input  almost_empty_o,
        input  rd_count_o,
        input  underflow_o
    );

    modport slave (
        input  rd_en_i,
        input  wp2rp_gray_i,
        output rptr_gray_o,
        output raddr_o,
        output empty_o,
        output almost_empty_o,
        output rd_count_o,
        output underflow_o
    );
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv #(
    parameter int W = 6
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end
endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty/almost-empty flags, fill level and underflow.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH       = 5,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input logic         rd_clk_i,
    input logic         rstn_i,
    rptr_empty_if.slave bus
);
    localparam int PW = ptr_w(PTR_WIDTH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] count_next;
    logic          rd_fire;

    // Gating by the registered empty flag keeps an unknown rd_en from moving rbin.
    assign rd_fire    = bus.rd_en_i & ~bus.empty_o;
    assign rbin_next  = rbin + PW'(rd_fire);
    assign rgray_next = PW'(bin2gray(MAX_W'(rbin_next)));
    assign count_next = wbin_s - rbin_next;
    assign bus.raddr_o = rbin[PTR_WIDTH-1:0];

    gray2bin_conv #(
        .W(PW)
    ) u_wp_g2b (
        .gray(bus.wp2rp_gray_i),
        .bin (wbin_s)
    );

    always_ff @(posedge rd_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rbin               <= '0;
            bus.rptr_gray_o    <= '0;
            bus.empty_o        <= 1'b1;
            bus.almost_empty_o <= 1'b1;
            bus.rd_count_o     <= '0;
            bus.underflow_o    <= 1'b0;
        end else begin
            rbin               <= rbin_next;
            bus.rptr_gray_o    <= rgray_next;
            bus.empty_o        <= (rgray_next == bus.wp2rp_gray_i);
            bus.almost_empty_o <= (count_next <= AE_TH);
            bus.rd_count_o     <= count_next;
            bus.underflow_o    <= bus.rd_en_i & bus.empty_o;
        end
    end
endmodule
